// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter slice: default width, range helper,
// the binary-to-Gray mapping and the step operation encoding.
package gray_pkg;

   localparam int unsigned GRAY_W = 4;
   localparam int unsigned MAX_W  = 32;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_INC,
      OP_DEC,
      OP_LOAD
   } step_op_e;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // All-ones value of a w-bit field, clamped to the widest supported counter.
   function automatic logic [MAX_W-1:0] max_of(input int unsigned w);
      logic [MAX_W-1:0] m;
      if (w >= MAX_W) begin
         m = '1;
      end else begin
         m = (MAX_W'(1) << w) - MAX_W'(1);
      end
      return m;
   endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder; each adjacent binary value maps to codes
// that differ in exactly one bit.
module bin2gray_enc #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   always_comb begin
      gray = bin ^ (bin >> 1);
   end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with synchronous load that keeps a binary count and presents a
// registered Gray code, a terminal-count flag and a one-cycle change strobe.
module gray_updown_counter
   import gray_pkg::*;
#(
   parameter int unsigned     WIDTH   = GRAY_W,
   parameter int unsigned     WRAP    = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] g,
   output logic             tc,
   output logic             valid
);

   localparam logic [WIDTH-1:0] MAX      = WIDTH'(max_of(WIDTH));
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_W'(RST_VAL)));
   localparam logic             DO_WRAP  = (WRAP != 0);

   step_op_e         op;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_n;
   logic [WIDTH-1:0] g_n;
   logic             tc_n;

   // Load outranks enable; direction only matters for an enabled step.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = up ? OP_INC : OP_DEC;
      end
   end

   always_comb begin
      bin_n = bin;
      unique case (op)
         OP_LOAD: bin_n = load_val;
         OP_INC: begin
            if (bin != MAX) begin
               bin_n = bin + WIDTH'(1);
            end else begin
               bin_n = DO_WRAP ? '0 : MAX;
            end
         end
         OP_DEC: begin
            if (bin != '0) begin
               bin_n = bin - WIDTH'(1);
            end else begin
               bin_n = DO_WRAP ? MAX : '0;
            end
         end
         default: bin_n = bin;
      endcase
   end

   bin2gray_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .bin  (bin_n),
      .gray (g_n)
   );

   // Terminal count follows the direction sampled this cycle, even when holding.
   always_comb begin
      tc_n = up ? (bin_n == MAX) : (bin_n == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin   <= RST_VAL;
         g     <= RST_GRAY;
         tc    <= 1'b0;
         valid <= 1'b0;
      end else begin
         bin   <= bin_n;
         g     <= g_n;
         valid <= (g_n != g);
         tc    <= tc_n;
      end
   end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: a wrapping and a saturating instance
// share stimulus and are compared against constants and an arithmetic model.
module tb_gray_updown_counter;

   localparam int unsigned W = 4;

   typedef struct {
      logic       load;
      logic [3:0] load_val;
      logic       en;
      logic       up;
      logic [3:0] exp_g;
      logic       exp_tc;
      logic       exp_valid;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] g_w, g_s;
   logic       tc_w, tc_s, valid_w, valid_s;

   int errors = 0;
   int checks = 0;

   int mb_w, mb_s;
   logic m_tc_w, m_tc_s, m_valid_w, m_valid_s;

   always #5 clk = ~clk;

   gray_updown_counter #(
      .WIDTH   (W),
      .WRAP    (1),
      .RST_VAL (4'd0)
   ) dut_w (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .g        (g_w),
      .tc       (tc_w),
      .valid    (valid_w)
   );

   gray_updown_counter #(
      .WIDTH   (W),
      .WRAP    (0),
      .RST_VAL (4'd0)
   ) dut_s (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .g        (g_s),
      .tc       (tc_s),
      .valid    (valid_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   // Counting rules over the range 0..15 with plain integer arithmetic.
   function automatic int next_bin(input int b, input bit wrap, input bit l, input int lv,
                                   input bit e, input bit u);
      if (l) return lv;
      if (!e) return b;
      if (u) return (b == 15) ? (wrap ? 0 : 15) : b + 1;
      return (b == 0) ? (wrap ? 15 : 0) : b - 1;
   endfunction

   task automatic model_reset();
      mb_w = 0; mb_s = 0;
      m_tc_w = 0; m_tc_s = 0; m_valid_w = 0; m_valid_s = 0;
   endtask

   task automatic check_model();
      chk("mdl_w_g", 32'(g_w), 32'(gray_of(mb_w)));
      chk("mdl_w_tc", 32'(tc_w), 32'(m_tc_w));
      chk("mdl_w_valid", 32'(valid_w), 32'(m_valid_w));
      chk("mdl_s_g", 32'(g_s), 32'(gray_of(mb_s)));
      chk("mdl_s_tc", 32'(tc_s), 32'(m_tc_s));
      chk("mdl_s_valid", 32'(valid_s), 32'(m_valid_s));
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      int nw, ns;
      @(posedge clk);
      nw = next_bin(mb_w, 1'b1, load, int'(load_val), en, up);
      ns = next_bin(mb_s, 1'b0, load, int'(load_val), en, up);
      m_valid_w = (gray_of(nw) != gray_of(mb_w));
      m_valid_s = (gray_of(ns) != gray_of(mb_s));
      m_tc_w = up ? (nw == 15) : (nw == 0);
      m_tc_s = up ? (ns == 15) : (ns == 0);
      mb_w = nw;
      mb_s = ns;
      #1;
      check_model();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t       up_tbl[17];
      logic [3:0] seq[17];
      logic [3:0] prev;

      seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
              4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000,
              4'b0001};
      for (int i = 0; i < 17; i++) begin
         up_tbl[i] = '{load: 1'b0, load_val: 4'd0, en: 1'b1, up: 1'b1,
                       exp_g: seq[i], exp_tc: (seq[i] == 4'b1000), exp_valid: 1'b1};
      end

      // Reset held with counting requested and the clock running.
      rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_g", 32'(g_w), 32'h0);
         chk("rst_tc", 32'(tc_w), 32'h0);
         chk("rst_valid", 32'(valid_w), 32'h0);
         chk("rst_g_sat", 32'(g_s), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Up-count through the full range and across the wrap.
      prev = g_w;
      for (int i = 0; i < 17; i++) begin
         load = up_tbl[i].load; load_val = up_tbl[i].load_val;
         en = up_tbl[i].en; up = up_tbl[i].up;
         tick();
         chk("up_g", 32'(g_w), 32'(up_tbl[i].exp_g));
         chk("up_tc", 32'(tc_w), 32'(up_tbl[i].exp_tc));
         chk("up_valid", 32'(valid_w), 32'(up_tbl[i].exp_valid));
         chk("up_hamming", 32'($countones(g_w ^ prev)), 32'd1);
         prev = g_w;
      end

      // Down-wrap from 0 to 15.
      load = 1'b1; load_val = 4'd0; en = 1'b0; up = 1'b0;
      tick();
      chk("dw_pre_g", 32'(g_w), 32'h0);
      chk("dw_pre_tc", 32'(tc_w), 32'h1);
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      chk("dw_g", 32'(g_w), 32'b1000);
      chk("dw_tc", 32'(tc_w), 32'h0);
      chk("dw_valid", 32'(valid_w), 32'h1);
      chk("dw_sat_g", 32'(g_s), 32'h0);
      chk("dw_sat_tc", 32'(tc_s), 32'h1);

      // Load beats enable; a repeated load of the same value does not strobe.
      load = 1'b1; load_val = 4'd2; en = 1'b0; up = 1'b1;
      tick();
      chk("ld_pre_g", 32'(g_w), 32'b0011);
      load_val = 4'b1010; en = 1'b1;
      tick();
      chk("ld_g", 32'(g_w), 32'b1111);
      chk("ld_valid", 32'(valid_w), 32'h1);
      tick();
      chk("ld2_g", 32'(g_w), 32'b1111);
      chk("ld2_valid", 32'(valid_w), 32'h0);

      // Saturation at the top end on the non-wrapping instance.
      load = 1'b1; load_val = 4'b1111; en = 1'b0; up = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat_g", 32'(g_s), 32'b1000);
         chk("sat_tc", 32'(tc_s), 32'h1);
         chk("sat_valid", 32'(valid_s), 32'h0);
      end

      // Asynchronous reset between edges, then resume.
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("ar_pre_g", 32'(g_w), 32'b0101);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("ar_g", 32'(g_w), 32'h0);
      chk("ar_tc", 32'(tc_w), 32'h0);
      chk("ar_valid", 32'(valid_w), 32'h0);
      chk("ar_g_sat", 32'(g_s), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_resume_g", 32'(g_w), 32'b0001);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         load = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 3) != 0);
         up = 1'($urandom_range(0, 1));
         tick();
         if (en && !load) begin
            chk("rnd_step_bits", 32'($countones(g_w ^ 4'(gray_of(mb_w)))), 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
